fpga_row_cfg_loader: RTL and testbench
======================================

# fpga_row_cfg_loader

Configuration loader that sits directly upstream of an FPGA row. It accepts a word-serial bitstream over a valid/ready handshake and assembles it in a shadow register. It verifies an XOR checksum, then commits atomically to the row's `brbselect`, `bsbselect` and `lbselect` buses. The row therefore never sees a partially loaded configuration.

## Interface
- `wire_width`, 3, routing channel width of the row
- `fpga_width`, 5, tiles per row
- `lb_cfg_size`, 5, config bits per logic block
- `WORD_W`, 8, bitstream word width
- Derived: BRB_W = fpga_width·wire_width·12 (180); BSB_W = (fpga_width-1)·wire_width²·12 (432); LB_W = (fpga_width-1)·lb_cfg_size (20); TOTAL = BRB_W+BSB_W+LB_W (632); NWORDS = ceil(TOTAL/WORD_W) (79)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `start`  in  1  begins a load; honoured only in IDLE
- `cfg_data`  in  WORD_W  bitstream word
- `cfg_valid`  in  1  `cfg_data` valid
- `cfg_ready`  out  1  loader accepts a word this cycle
- `brbselect`  out  BRB_W  committed routing-block config
- `bsbselect`  out  BSB_W  committed switch-block config
- `lbselect`  out  LB_W  committed logic-block config
- `busy`  out  1  high in LOAD or CHECK
- `done`  out  1  one-cycle pulse after a successful commit
- `err`  out  1  checksum mismatch flag; sticky until the next accepted `start`

## Operation
- States: IDLE, LOAD, CHECK.
- **IDLE:**
  - `cfg_ready`=0.
  - `start`=1 moves to LOAD. The same edge clears the word counter, the running checksum and `err`.
- **LOAD:**
  - `cfg_ready`=1.
  - On each handshake (`cfg_valid`&`cfg_ready`):
    - the shadow register (NWORDS·WORD_W bits) shifts right by WORD_W, with `cfg_data` inserted at the MSBs;
    - the checksum is XORed with `cfg_data`;
    - the counter increments.
  - The handshake that delivers word NWORDS-1 moves to CHECK.
- **CHECK:**
  - `cfg_ready`=1.
  - The next handshaked word is the checksum.
  - If it equals the running XOR of all NWORDS words: the same edge copies the shadow into the outputs, and the state returns to IDLE with `done`=1 for the following cycle.
  - Otherwise: the outputs are unchanged, `err`=1, and the state returns to IDLE.
- **Bit mapping:**
  - Stream word i, bit j maps to bit k = i·WORD_W+j of the concatenation {lbselect, bsbselect, brbselect}. Word 0 therefore lands in `brbselect[WORD_W-1:0]`.
  - Padding bits (k ≥ TOTAL) in the last word are discarded but are included in the checksum.
- `start` while `busy` is ignored. There is no abort other than `rst`.
- `cfg_valid` with `cfg_ready`=0 has no effect, and the word is not consumed.
- Counter width is clog2(NWORDS+1). The counter never wraps, because the state leaves LOAD exactly at NWORDS.

## Timing
- **Reset (async assert, sync deassert expected):** state IDLE; shadow, outputs, counter and checksum all 0; `cfg_ready`=`busy`=`done`=`err`=0.
- **`rst` asserted mid-load:** the same reset values apply, the partial load is lost, and the committed config also goes to 0.
- `start` sampled high at edge E: `busy`=1 and `cfg_ready`=1 from E onward. The first word can be accepted at edge E+1.
- **Throughput:** one word per cycle. Minimum load is 1 (start) + NWORDS + 1 (checksum) handshake edges, i.e. 81 cycles at defaults.
- **Outputs:**
  - Commit outputs change only on the checksum-accept edge.
  - `done` is high exactly during the cycle after that edge.
  - `busy` falls on the same edge.
- `err` rises on the mismatch edge and stays high until the next accepted `start`.
- `cfg_ready` is registered/state-decoded and has no combinational path from `cfg_valid`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `cfg_ready`=0.
- **Full load (defaults):**
  - Stimulus: start, then words i=0..78 with value i, then checksum 0x4F.
  - Required: `done` pulses once; `brbselect[15:0]`=0x0100; `lbselect`=0x4E4D4; `busy` low after 81 edges.
- **Bad checksum:** repeat the full load with checksum 0x00 → `err`=1, no `done`, outputs retain the previous load's values.
- **Backpressure gaps:** same stream as the full load, with `cfg_valid` dropped for 1–3 cycles between words → identical outputs; the counter advances only on handshakes.
- **Mid-load reset:** after 40 words, pulse `rst` → outputs 0, IDLE. A subsequent full load commits the correct values.
- **Start while busy:** pulse `start` at word 10 → ignored; the load completes normally with `done` and the expected values.

Source files
------------

// File: rtl/fpga_row_cfg_loader.sv
// Word-serial configuration loader for one FPGA row. Words are shifted into a
// shadow register, checked against a trailing XOR checksum word, and only then
// committed in one edge to the row's select buses.
module fpga_row_cfg_loader #(
  parameter int unsigned wire_width  = 3,
  parameter int unsigned fpga_width  = 5,
  parameter int unsigned lb_cfg_size = 5,
  parameter int unsigned WORD_W      = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic [WORD_W-1:0]                               cfg_data,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  output logic [fpga_width*wire_width*12-1:0]             brbselect,
  output logic [(fpga_width-1)*wire_width*wire_width*12-1:0] bsbselect,
  output logic [(fpga_width-1)*lb_cfg_size-1:0]           lbselect,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            err
);

  localparam int unsigned BRB_W  = fpga_width * wire_width * 12;
  localparam int unsigned BSB_W  = (fpga_width - 1) * wire_width * wire_width * 12;
  localparam int unsigned LB_W   = (fpga_width - 1) * lb_cfg_size;
  localparam int unsigned TOTAL  = BRB_W + BSB_W + LB_W;
  localparam int unsigned NWORDS = (TOTAL + WORD_W - 1) / WORD_W;
  localparam int unsigned SH_W   = NWORDS * WORD_W;
  localparam int unsigned CNT_W  = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck
  } state_e;

  state_e              r_state;
  logic [SH_W-1:0]     r_shadow;
  logic [WORD_W-1:0]   r_csum;
  logic [CNT_W-1:0]    r_cnt;
  logic [BRB_W-1:0]    r_brb;
  logic [BSB_W-1:0]    r_bsb;
  logic [LB_W-1:0]     r_lb;
  logic                r_cfg_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_hs;
  logic                w_last;
  logic                w_csum_ok;

  // Handshake and decode of the final data word / checksum match.
  assign w_hs      = cfg_valid & r_cfg_ready;
  assign w_last    = (r_cnt == CNT_W'(NWORDS - 1));
  assign w_csum_ok = (cfg_data == r_csum);

  // Shadow assembly: shift right so word 0 ends up at the LSBs after NWORDS words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_csum   <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_state == StIdle && start) begin
        r_csum <= '0;
        r_cnt  <= '0;
      end else if (r_state == StLoad && w_hs) begin
        r_shadow <= {cfg_data, r_shadow[SH_W-1:WORD_W]};
        r_csum   <= r_csum ^ cfg_data;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Control FSM with registered handshake/status outputs and the atomic commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_brb       <= '0;
      r_bsb       <= '0;
      r_lb        <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StLoad;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
          end
        end
        StLoad: begin
          if (w_hs && w_last) begin
            r_state <= StCheck;
          end
        end
        StCheck: begin
          if (w_hs) begin
            r_state     <= StIdle;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            if (w_csum_ok) begin
              // Padding bits above TOTAL are dropped here.
              {r_lb, r_bsb, r_brb} <= r_shadow[TOTAL-1:0];
              r_done               <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= StIdle;
          r_cfg_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign brbselect = r_brb;
  assign bsbselect = r_bsb;
  assign lbselect  = r_lb;

endmodule

// File: tb/tb_fpga_row_cfg_loader.sv
// Self-checking bench for fpga_row_cfg_loader: directed loads from the test
// plan followed by randomized loads, checked against a bit-mapping model.
module tb_fpga_row_cfg_loader;

  localparam int unsigned WIRE_W = 3;
  localparam int unsigned FPGA_W = 5;
  localparam int unsigned LB_CFG = 5;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned BRB_W  = FPGA_W * WIRE_W * 12;
  localparam int unsigned BSB_W  = (FPGA_W - 1) * WIRE_W * WIRE_W * 12;
  localparam int unsigned LB_W   = (FPGA_W - 1) * LB_CFG;
  localparam int unsigned TOTAL  = BRB_W + BSB_W + LB_W;
  localparam int unsigned NWORDS = (TOTAL + WORD_W - 1) / WORD_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [BRB_W-1:0]  brbselect;
  logic [BSB_W-1:0]  bsbselect;
  logic [LB_W-1:0]   lbselect;
  logic              busy;
  logic              done;
  logic              err;

  fpga_row_cfg_loader #(
    .wire_width (WIRE_W),
    .fpga_width (FPGA_W),
    .lb_cfg_size(LB_CFG),
    .WORD_W     (WORD_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .brbselect(brbselect),
    .bsbselect(bsbselect),
    .lbselect (lbselect),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int done_cnt;

  logic [WORD_W-1:0] words [NWORDS];
  logic [BRB_W-1:0]  exp_brb;
  logic [BSB_W-1:0]  exp_bsb;
  logic [LB_W-1:0]   exp_lb;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Model: stream word i bit j is bit i*WORD_W+j of {lbselect, bsbselect, brbselect}.
  task automatic model_commit();
    logic [TOTAL-1:0] cat;
    for (int k = 0; k < TOTAL; k++) cat[k] = words[k / WORD_W][k % WORD_W];
    exp_brb = cat[BRB_W-1:0];
    exp_bsb = cat[BRB_W+BSB_W-1:BRB_W];
    exp_lb  = cat[TOTAL-1:BRB_W+BSB_W];
  endtask

  task automatic check_cfg(input string tag);
    check_eq({tag, "_brb"}, 640'(brbselect), 640'(exp_brb));
    check_eq({tag, "_bsb"}, 640'(bsbselect), 640'(exp_bsb));
    check_eq({tag, "_lb"},  640'(lbselect),  640'(exp_lb));
  endtask

  task automatic check_zero_state(input string tag);
    check_eq({tag, "_ready"}, 640'(cfg_ready), 640'(0));
    check_eq({tag, "_busy"},  640'(busy),      640'(0));
    check_eq({tag, "_done"},  640'(done),      640'(0));
    check_eq({tag, "_err"},   640'(err),       640'(0));
    check_cfg(tag);
  endtask

  // One complete load. Gaps of min_gap..max_gap idle cycles precede each word.
  // poke_at: word index at which start is pulsed; reset_at: word index before
  // which rst is pulsed mid-cycle (negative disables either).
  task automatic run_load(input string tag, input int min_gap, input int max_gap,
                          input logic [WORD_W-1:0] ck, input int poke_at, input int reset_at);
    logic [WORD_W-1:0] x;
    logic              ok;
    int                dc0;
    int                ng;
    x = '0;
    for (int i = 0; i < NWORDS; i++) x = x ^ words[i];
    ok = (ck == x);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq({tag, "_busy_after_start"},  640'(busy),      640'(1));
    check_eq({tag, "_ready_after_start"}, 640'(cfg_ready), 640'(1));
    check_eq({tag, "_err_cleared"},       640'(err),       640'(0));

    for (int i = 0; i < NWORDS; i++) begin
      if (i == reset_at) begin
        #2 rst = 1'b1;
        #1;
        exp_brb = '0;
        exp_bsb = '0;
        exp_lb  = '0;
        check_zero_state({tag, "_midreset"});
        @(negedge clk) rst = 1'b0;
        return;
      end
      ng = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
      repeat (ng) begin
        @(posedge clk); #1;
      end
      cfg_valid = 1'b1;
      cfg_data  = words[i];
      if (i == poke_at) start = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      start     = 1'b0;
    end

    // Gaps must not advance the counter: still waiting for the checksum word.
    check_eq({tag, "_busy_before_ck"}, 640'(busy), 640'(1));
    dc0       = done_cnt;
    cfg_valid = 1'b1;
    cfg_data  = ck;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (ok) model_commit();
    check_eq({tag, "_busy_after_ck"},  640'(busy),      640'(0));
    check_eq({tag, "_ready_after_ck"}, 640'(cfg_ready), 640'(0));
    check_eq({tag, "_done_pulse"},     640'(done),      640'(ok));
    check_eq({tag, "_err"},            640'(err),       640'(!ok));
    check_cfg(tag);
    @(posedge clk); #1;
    check_eq({tag, "_done_low"},  640'(done), 640'(0));
    check_eq({tag, "_done_once"}, 640'(done_cnt - dc0), 640'(ok));
    check_eq({tag, "_err_sticky"}, 640'(err), 640'(!ok));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    done_cnt  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    exp_brb   = '0;
    exp_bsb   = '0;
    exp_lb    = '0;
    #3;
    check_zero_state("reset");
    @(negedge clk); @(negedge clk) rst = 1'b0;

    // Valid while idle is not consumed and changes nothing.
    cfg_valid = 1'b1;
    cfg_data  = 8'hA5;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check_zero_state("idle_valid");

    // Directed full load, words equal to their index.
    for (int i = 0; i < NWORDS; i++) words[i] = WORD_W'(i);
    run_load("full", 0, 0, 8'h4F, -1, -1);
    check_eq("full_brb_lo", 640'(brbselect[15:0]), 640'(16'h0100));
    check_eq("full_lb_const", 640'(lbselect), 640'(20'h4E4D4));

    run_load("badck", 0, 0, 8'h00, -1, -1);
    run_load("gaps", 1, 3, 8'h4F, -1, -1);
    run_load("midrst", 0, 0, 8'h4F, -1, 40);
    run_load("after_rst", 0, 0, 8'h4F, -1, -1);
    run_load("start_busy", 0, 0, 8'h4F, 10, -1);

    // Randomized loads, roughly a quarter with a corrupted checksum.
    for (int t = 0; t < 6; t++) begin
      logic [WORD_W-1:0] x;
      x = '0;
      for (int i = 0; i < NWORDS; i++) begin
        words[i] = WORD_W'($urandom);
        x = x ^ words[i];
      end
      if ($urandom_range(3, 0) == 0) x = x ^ WORD_W'($urandom_range(255, 1));
      run_load($sformatf("rand%0d", t), 0, 2, x, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
